// File: rtl/dm_arb_pkg.sv
// Shared types, defaults and helpers for the data-memory arbiter.
package dm_arb_pkg;

    // Arbiter ownership state; kept as plain constants for legacy tools.
    typedef logic [0:0] arb_state_t;
    localparam arb_state_t C_OWN   = 1'b0;
    localparam arb_state_t D_BURST = 1'b1;

    // Default configuration of the arbiter.
    localparam int DATA_W_DEF     = 32;
    localparam int ADDR_W_DEF     = 32;
    localparam int DEPTH_DEF      = 64;
    localparam int STARVE_MAX_DEF = 4;
    localparam int BURST_MAX_DEF  = 4;

    // Bits needed to hold a count of 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/dm_arb_sat_cnt.sv
// Clear/increment counter that stops at TC_VAL and flags the terminal count.
module dm_arb_sat_cnt
    import dm_arb_pkg::*;
#(
    parameter int WIDTH  = 3,
    parameter int TC_VAL = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    logic [WIDTH-1:0] cnt;

    assign tc = (cnt == WIDTH'(TC_VAL));

    // Count events, holding at the terminal value until cleared.
    // NOTE: clocked state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (inc && !tc) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Single-port data-memory arbiter: CPU (port C) has priority, a starvation
// counter forces fixed-length DMA (port D) bursts, addresses are range-checked.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int BURST_MAX  = BURST_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_rvalid,
    output logic              addr_err,
    output logic [ADDR_W-1:0] Mem_ID,
    output logic              Mem_Write,
    output logic              Mem_Read,
    output logic [DATA_W-1:0] Mem_WData,
    input  logic [DATA_W-1:0] Mem_RData
);

    localparam int WAIT_W  = cnt_width(STARVE_MAX);
    localparam int BURST_W = cnt_width(BURST_MAX);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic              c_gnt;
    logic              d_gnt;
    logic              wait_tc;
    logic              burst_tc;
    logic              g_any;
    logic              g_we;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;
    logic              g_in_range;

    // Grant decode: CPU first in C_OWN, DMA only during a forced burst; nothing in reset.
    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        c_gnt = 1'b0;
        d_gnt = 1'b0;
        if (rst_n) begin
            if (state == C_OWN) begin
                c_gnt = cpu_req;
                d_gnt = dma_req & ~cpu_req;
            end else begin
                d_gnt = dma_req;
            end
        end
    end

    assign cpu_stall = rst_n & cpu_req & ~c_gnt;
    assign dma_gnt   = d_gnt;
    assign g_any     = c_gnt | d_gnt;

    // Memory bus mux: the granted port drives address, direction and write data.
    always_comb begin
        g_we    = 1'b0;
        g_addr  = '0;
        g_wdata = '0;
        if (c_gnt) begin
            g_we    = cpu_we;
            g_addr  = cpu_addr;
            g_wdata = cpu_wdata;
        end else if (d_gnt) begin
            g_we    = dma_we;
            g_addr  = dma_addr;
            g_wdata = dma_wdata;
        end
    end

    // Out-of-range accesses are granted but never reach the memory array.
    assign g_in_range = (g_addr < ADDR_W'(DEPTH));
    assign Mem_ID     = g_addr;
    assign Mem_WData  = g_wdata;
    assign Mem_Write  = g_any & g_we & g_in_range;
    assign Mem_Read   = g_any & ~g_we & g_in_range;
    assign cpu_rdata  = (c_gnt && !cpu_we && g_in_range) ? Mem_RData : '0;

    // Ownership transitions: enter a burst on starvation, leave on burst end or DMA idle.
    always_comb begin
        state_nxt = state;
        if (state == C_OWN) begin
            if (dma_req && !d_gnt && wait_tc) begin
                state_nxt = D_BURST;
            end
        end else if (!dma_req || (d_gnt && burst_tc)) begin
            state_nxt = C_OWN;
        end
    end

    // Consecutive cycles the DMA has been kept waiting.
    dm_arb_sat_cnt #(
        .WIDTH  (WAIT_W),
        .TC_VAL (STARVE_MAX - 1)
    ) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (d_gnt | ~dma_req),
        .inc   (dma_req & ~d_gnt),
        .tc    (wait_tc)
    );

    // DMA grants taken in the current forced burst; idle outside bursts.
    dm_arb_sat_cnt #(
        .WIDTH  (BURST_W),
        .TC_VAL (BURST_MAX - 1)
    ) u_burst_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   ((state == C_OWN) | (state_nxt == C_OWN)),
        .inc   (d_gnt),
        .tc    (burst_tc)
    );

    // Ownership state, registered DMA read return and sticky range error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= C_OWN;
            dma_rdata  <= '0;
            dma_rvalid <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            dma_rvalid <= d_gnt & ~dma_we;
            if (d_gnt && !dma_we) begin
                dma_rdata <= g_in_range ? Mem_RData : '0;
            end
            if (g_any && !g_in_range) begin
                addr_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_dm_arbiter;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 32;
    localparam int DEPTH      = 64;
    localparam int STARVE_MAX = 4;
    localparam int BURST_MAX  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cpu_req, cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic              cpu_stall;
    logic              dma_req, dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata, dma_rdata;
    logic              dma_gnt, dma_rvalid, addr_err;
    logic [ADDR_W-1:0] Mem_ID;
    logic              Mem_Write, Mem_Read;
    logic [DATA_W-1:0] Mem_WData, Mem_RData;

    int n_vec = 0;
    int n_err = 0;

    // Physical memory seen by the DUT; out-of-range reads return garbage.
    logic [DATA_W-1:0] mem [DEPTH];
    assign Mem_RData = (Mem_ID < 32'(DEPTH)) ? mem[Mem_ID[5:0]] : 32'hDEAD_BEEF;
    always @(negedge clk) if (Mem_Write) mem[Mem_ID[5:0]] <= Mem_WData;

    always #5 clk = ~clk;

    dm_arbiter #(
        .DATA_W (DATA_W), .ADDR_W (ADDR_W), .DEPTH (DEPTH),
        .STARVE_MAX (STARVE_MAX), .BURST_MAX (BURST_MAX)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .cpu_req (cpu_req), .cpu_we (cpu_we), .cpu_addr (cpu_addr),
        .cpu_wdata (cpu_wdata), .cpu_rdata (cpu_rdata), .cpu_stall (cpu_stall),
        .dma_req (dma_req), .dma_we (dma_we), .dma_addr (dma_addr),
        .dma_wdata (dma_wdata), .dma_gnt (dma_gnt), .dma_rdata (dma_rdata),
        .dma_rvalid (dma_rvalid), .addr_err (addr_err),
        .Mem_ID (Mem_ID), .Mem_Write (Mem_Write), .Mem_Read (Mem_Read),
        .Mem_WData (Mem_WData), .Mem_RData (Mem_RData)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, 32'(act), 32'(exp));
    endtask

    // Behavioural model: ownership as "waited cycles" and "burst grants taken".
    logic [DATA_W-1:0] ref_mem [DEPTH];
    bit                m_burst = 0;
    int                m_wait = 0;
    int                m_bgrants = 0;
    logic              m_rvalid = 1'b0;
    logic [DATA_W-1:0] m_rdata = '0;
    logic              m_err = 1'b0;
    bit                model_ok = 0;
    bit                chk_en = 1;

    task automatic compare_cycle();
        logic              ec, ed, g, gwe, ir;
        logic [ADDR_W-1:0] ga;
        logic [DATA_W-1:0] gd, exp_crd;
        ec = 1'b0;
        ed = 1'b0;
        if (rst_n) begin
            if (!m_burst) begin
                ec = cpu_req;
                ed = dma_req && !cpu_req;
            end else begin
                ed = dma_req;
            end
        end
        g   = ec || ed;
        ga  = ec ? cpu_addr  : (ed ? dma_addr  : '0);
        gwe = ec ? cpu_we    : (ed ? dma_we    : 1'b0);
        gd  = ec ? cpu_wdata : (ed ? dma_wdata : '0);
        ir  = (ga < 32'(DEPTH));
        exp_crd = (ec && !cpu_we && ir) ? ref_mem[ga[5:0]] : '0;

        check1("m_dma_gnt",   dma_gnt,   ed);
        check1("m_cpu_stall", cpu_stall, rst_n && cpu_req && !ec);
        check1("m_mem_write", Mem_Write, g && gwe && ir);
        check1("m_mem_read",  Mem_Read,  g && !gwe && ir);
        check ("m_mem_id",    Mem_ID,    ga);
        check ("m_mem_wdata", Mem_WData, gd);
        check ("m_cpu_rdata", cpu_rdata, exp_crd);
        if (model_ok) begin
            check1("m_dma_rvalid", dma_rvalid, m_rvalid);
            check ("m_dma_rdata",  dma_rdata,  m_rdata);
            check1("m_addr_err",   addr_err,   m_err);
        end

        if (!rst_n) begin
            m_burst = 0; m_wait = 0; m_bgrants = 0;
            m_rvalid = 1'b0; m_rdata = '0; m_err = 1'b0;
            model_ok = 1;
        end else begin
            m_rvalid = ed && !dma_we;
            if (m_rvalid) m_rdata = ir ? ref_mem[ga[5:0]] : '0;
            if (g && gwe && ir) ref_mem[ga[5:0]] = gd;
            if (g && !ir) m_err = 1'b1;
            if (!m_burst) begin
                if (dma_req && !ed) begin
                    m_wait++;
                    if (m_wait == STARVE_MAX) begin
                        m_burst = 1; m_wait = 0; m_bgrants = 0;
                    end
                end else begin
                    m_wait = 0;
                end
            end else begin
                m_wait = 0;
                if (!dma_req) begin
                    m_burst = 0;
                end else begin
                    m_bgrants++;
                    if (m_bgrants == BURST_MAX) m_burst = 0;
                end
            end
        end
    endtask

    // Compare process: outputs are sampled mid-cycle, before the negedge memory write.
    always begin
        @(posedge clk);
        #4;
        if (chk_en) compare_cycle();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_dma(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
        dma_req = req; dma_we = we; dma_addr = a; dma_wdata = d;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = 32'hC0DE_0000 + 32'(i);
            ref_mem[i] = 32'hC0DE_0000 + 32'(i);
        end
        rst_n = 1'b0;
        set_cpu(1, 1, 3, 32'h1111);
        set_dma(1, 1, 4, 32'h2222);

        // Reset with both ports requesting.
        for (int i = 0; i < 2; i++) begin
            tick(); #2;
            check1("rst_mem_write", Mem_Write, 1'b0);
            check1("rst_mem_read",  Mem_Read,  1'b0);
            check1("rst_dma_gnt",   dma_gnt,   1'b0);
            check1("rst_cpu_stall", cpu_stall, 1'b0);
        end
        tick();
        rst_n = 1'b1;
        set_cpu(0, 0, 0, 0);
        set_dma(0, 0, 0, 0);
        #2;
        check1("idle_dma_rvalid", dma_rvalid, 1'b0);
        check1("idle_addr_err",   addr_err,   1'b0);
        check ("idle_dma_rdata",  dma_rdata,  32'h0);
        check ("idle_cpu_rdata",  cpu_rdata,  32'h0);
        check ("idle_mem_id",     Mem_ID,     32'h0);

        // CPU write then read back.
        tick(); set_cpu(1, 1, 5, 32'h1234); #2;
        check1("wr_mem_write", Mem_Write, 1'b1);
        check1("wr_stall",     cpu_stall, 1'b0);
        tick(); set_cpu(1, 0, 5, 0); #2;
        check ("rd_cpu_rdata", cpu_rdata, 32'h1234);
        check1("rd_stall",     cpu_stall, 1'b0);

        // Both requesting steadily: 4 CPU grants, 4 forced DMA grants, repeat.
        for (int i = 0; i < 16; i++) begin
            tick(); set_cpu(1, 0, 1, 0); set_dma(1, 0, 2, 0); #2;
            check1("starve_stall", cpu_stall, (i % 8) >= 4);
            check1("starve_dgnt",  dma_gnt,   (i % 8) >= 4);
        end

        // DMA read of addr 43 in an idle slot.
        tick(); set_cpu(0, 0, 0, 0); set_dma(1, 0, 43, 0); #2;
        check1("dma43_gnt", dma_gnt, 1'b1);
        tick(); set_dma(0, 0, 0, 0); #2;
        check1("dma43_rvalid", dma_rvalid, 1'b1);
        check ("dma43_rdata",  dma_rdata,  32'hC0DE_002B);
        tick(); #2;
        check1("dma43_rvalid_drop", dma_rvalid, 1'b0);

        // Out-of-range CPU write.
        tick(); set_cpu(1, 1, 64, 32'h0BAD); #2;
        check1("oor_mem_write", Mem_Write, 1'b0);
        tick(); set_cpu(0, 0, 0, 0); #2;
        check1("oor_addr_err", addr_err, 1'b1);
        check ("oor_mem0",     mem[0],   32'hC0DE_0000);
        tick(); #2;
        check1("oor_addr_err_sticky", addr_err, 1'b1);

        // Reset during the second burst cycle.
        for (int i = 0; i < 6; i++) begin
            tick(); set_cpu(1, 0, 7, 0); set_dma(1, 0, 9, 0); rst_n = (i != 5); #2;
            if (i == 4) check1("mid_burst_gnt", dma_gnt, 1'b1);
            if (i == 5) begin
                check1("mid_rst_dgnt",  dma_gnt,   1'b0);
                check1("mid_rst_stall", cpu_stall, 1'b0);
                check1("mid_rst_read",  Mem_Read,  1'b0);
            end
        end
        for (int i = 0; i < 6; i++) begin
            tick(); rst_n = 1'b1; #2;
            check1("post_rst_stall", cpu_stall, i >= 4);
            check1("post_rst_dgnt",  dma_gnt,   i >= 4);
            if (i == 0) begin
                check1("post_rst_err",    addr_err,   1'b0);
                check1("post_rst_rvalid", dma_rvalid, 1'b0);
            end
        end

        // Randomized traffic; the compare process checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            tick();
            rst_n = ($urandom_range(0, 199) != 0);
            set_cpu(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)),
                    32'($urandom_range(0, 70)), $urandom);
            set_dma(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
                    32'($urandom_range(0, 70)), $urandom);
        end

        tick();
        rst_n = 1'b1;
        set_cpu(0, 0, 0, 0);
        set_dma(0, 0, 0, 0);
        tick();
        tick();
        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
